// File: rtl/shiftreg_button_scanner.sv
// Scan sequencer for a 74HC165-style button shift register chain.
// Optional build macro: BUTTON_DEBOUNCE_EN (two-scan agreement filter).
module shiftreg_button_scanner #(
    parameter int CLK_DIV   = 25,
    parameter int NUM_BITS  = 16,
    parameter int GAP_TICKS = 100
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    output logic                shiftreg_clk,
    output logic                shiftreg_loadn,
    input  logic                shiftreg_out,
    output logic [NUM_BITS-1:0] buttons,
    output logic                buttons_valid,
    output logic                buttons_changed
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(NUM_BITS);
    localparam int GAP_W = (GAP_TICKS > 2) ? $clog2(GAP_TICKS) : 1;

    typedef enum logic [1:0] {
        LOAD,
        LOW,
        HIGH,
        IDLE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [NUM_BITS-1:1] raw;
    logic [NUM_BITS-1:0] candidate;
    logic [NUM_BITS-1:0] next_buttons;
    logic                tick;
    logic                last_bit;
    logic                gap_done;
    logic                publish;

    assign tick      = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign last_bit  = (bit_cnt == BIT_W'(NUM_BITS - 1));
    assign gap_done  = (int'(gap_cnt) + 1 >= GAP_TICKS);
    assign publish   = tick && (state == LOW) && last_bit;
    // The final bit is taken straight from the pin on the publish edge
    assign candidate = ~{raw, shiftreg_out};

`ifdef BUTTON_DEBOUNCE_EN
    logic [NUM_BITS-1:0] prev_raw;

    assign next_buttons = (candidate == ~prev_raw) ? candidate : buttons;

    // Remember each completed raw scan for the agreement test
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_raw <= '0;
        end else if (publish) begin
            prev_raw <= {raw, shiftreg_out};
        end
    end
`else
    assign next_buttons = candidate;
`endif

    // Free-running tick divider
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Next-state decode; transitions only on tick cycles
    always_comb begin
        state_next = state;
        if (tick) begin
            unique case (state)
                LOAD: state_next = LOW;
                LOW: begin
                    if (!last_bit) begin
                        state_next = HIGH;
                    end else if (GAP_TICKS == 0 && enable) begin
                        state_next = LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end
                HIGH: state_next = LOW;
                IDLE: begin
                    if (gap_done && enable) begin
                        state_next = LOAD;
                    end
                end
                default: state_next = LOAD;
            endcase
        end
    end

    // State register; pin outputs registered from next state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= LOAD;
            shiftreg_clk   <= 1'b0;
            shiftreg_loadn <= 1'b1;
        end else begin
            state          <= state_next;
            shiftreg_clk   <= (state_next == HIGH);
            shiftreg_loadn <= (state_next != LOAD);
        end
    end

    // Bit and gap counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else if (tick) begin
            if (state == LOAD) begin
                bit_cnt <= '0;
            end else if (state == HIGH) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (state != IDLE) begin
                gap_cnt <= '0;
            end else if (!gap_done) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
        end
    end

    // Capture serial data MSB first at the end of each low phase
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            raw <= '0;
        end else if (tick && state == LOW && !last_bit) begin
            raw[BIT_W'(NUM_BITS - 1) - bit_cnt] <= shiftreg_out;
        end
    end

    // Publish the scan result and status pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buttons         <= '0;
            buttons_valid   <= 1'b0;
            buttons_changed <= 1'b0;
        end else begin
            buttons_valid   <= publish;
            buttons_changed <= publish && (next_buttons != buttons);
            if (publish) begin
                buttons <= next_buttons;
            end
        end
    end

endmodule

// File: tb/tb_shiftreg_button_scanner.sv
// Directed bench for shiftreg_button_scanner with 74HC165 models.
// Expectations follow BUTTON_DEBOUNCE_EN when the bench is built with it.
module tb_shiftreg_button_scanner;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        shiftreg_clk, shiftreg_loadn, sdata;
    logic [15:0] buttons;
    logic        buttons_valid, buttons_changed;
    logic        g_clk, g_loadn, g_sdata;
    logic [15:0] g_buttons;
    logic        g_valid, g_changed;
    logic [15:0] pins = 16'hFFFE;
    logic [15:0] g_pins = 16'h0F0F;
    logic [15:0] sr, g_sr;
    logic [15:0] exp_btn, exp_prev_raw;
    int          cyc, rises, checks, errors;
    int          at, last;
    logic        bad;

    shiftreg_button_scanner #(
        .CLK_DIV(2), .NUM_BITS(16), .GAP_TICKS(2)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .shiftreg_clk(shiftreg_clk), .shiftreg_loadn(shiftreg_loadn),
        .shiftreg_out(sdata), .buttons(buttons),
        .buttons_valid(buttons_valid), .buttons_changed(buttons_changed)
    );

    shiftreg_button_scanner #(
        .CLK_DIV(2), .NUM_BITS(16), .GAP_TICKS(0)
    ) dut_gap0 (
        .clock(clock), .reset(reset), .enable(enable),
        .shiftreg_clk(g_clk), .shiftreg_loadn(g_loadn),
        .shiftreg_out(g_sdata), .buttons(g_buttons),
        .buttons_valid(g_valid), .buttons_changed(g_changed)
    );

    always #5 clock = ~clock;

    // 74HC165 models: async parallel load, shift toward Q7 on clk rise
    always @(posedge shiftreg_clk or negedge shiftreg_loadn)
        if (!shiftreg_loadn) sr <= pins;
        else sr <= {sr[14:0], 1'b0};
    assign sdata = sr[15];

    always @(posedge g_clk or negedge g_loadn)
        if (!g_loadn) g_sr <= g_pins;
        else g_sr <= {g_sr[14:0], 1'b0};
    assign g_sdata = g_sr[15];

    // Edges since reset release, and shift clock rises
    always @(posedge clock or posedge reset)
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;

    always @(posedge shiftreg_clk or posedge reset)
        if (reset) rises <= 0;
        else rises <= rises + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(input bit g, output int t);
        t = -1;
        for (int n = 0; n < 400; n++) begin
            @(posedge clock);
            #1;
            if ((g ? g_valid : buttons_valid) === 1'b1) begin
                t = cyc;
                break;
            end
        end
        chk("valid_seen", 32'(t != -1), 32'd1);
    endtask

    task automatic check_scan(input string tag, input logic [15:0] p);
        logic [15:0] cand, nb;
        cand = ~p;
`ifdef BUTTON_DEBOUNCE_EN
        nb = (cand == ~exp_prev_raw) ? cand : exp_btn;
        exp_prev_raw = p;
`else
        nb = cand;
`endif
        chk({tag, "_buttons"}, 32'(buttons), 32'(nb));
        chk({tag, "_changed"}, 32'(buttons_changed), 32'(nb != exp_btn));
        exp_btn = nb;
    endtask

    task automatic do_reset(input logic [15:0] p);
        reset = 1'b1;
        pins = p;
        exp_btn = '0;
        exp_prev_raw = '0;
        edges(2);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_btn = '0;
        exp_prev_raw = '0;

        // Reset state
        #12;
        chk("rst_pins", 32'({shiftreg_clk, shiftreg_loadn}), 32'b01);
        chk("rst_buttons", 32'(buttons), 32'h0);
        chk("rst_pulses", 32'({buttons_valid, buttons_changed}), 32'b00);
        @(negedge clock);
        reset = 1'b0;

        // First scan, bit0 pressed
        edges(1);
        chk("load_low", 32'({shiftreg_loadn, shiftreg_clk}), 32'b00);
        edges(2);
        chk("load_done", 32'(shiftreg_loadn), 32'd1);
        edges(60);
        chk("valid_early", 32'(buttons_valid), 32'd0);
        edges(1);
        chk("valid_64", 32'(buttons_valid), 32'd1);
        chk("first_at", 32'(cyc), 32'd64);
        chk("clk_rises", 32'(rises), 32'd15);
        check_scan("scan1", 16'hFFFE);
        last = cyc;
        pins = 16'hA5F0;
        edges(1);
        chk("valid_pulse", 32'({buttons_valid, buttons_changed}), 32'b00);

        // Steady pattern over three scans
        for (int i = 0; i < 3; i++) begin
            wait_valid(1'b0, at);
            chk("period", 32'(at - last), 32'd68);
            check_scan("steady", 16'hA5F0);
            last = at;
        end

        // Alternating pins, then a held pattern
        do_reset(16'hFFFF);
        wait_valid(1'b0, at);
        chk("alt_first_at", 32'(at), 32'd64);
        check_scan("alt0", 16'hFFFF);
        pins = 16'h0000;
        wait_valid(1'b0, at);
        check_scan("alt1", 16'h0000);
        pins = 16'hFFFF;
        wait_valid(1'b0, at);
        check_scan("alt2", 16'hFFFF);
        pins = 16'h0000;
        wait_valid(1'b0, at);
        check_scan("hold0", 16'h0000);
        wait_valid(1'b0, at);
        check_scan("hold1", 16'h0000);
        last = at;

        // Drop enable mid-scan
        pins = 16'h3C3C;
        edges(23);
        enable = 1'b0;
        wait_valid(1'b0, at);
        chk("dis_period", 32'(at - last), 32'd68);
        check_scan("dis_scan", 16'h3C3C);
        last = at;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            edges(1);
            if (shiftreg_loadn !== 1'b1 || shiftreg_clk !== 1'b0) bad = 1'b1;
        end
        chk("idle_hold", 32'(bad), 32'd0);
        enable = 1'b1;
        edges(1);
        chk("reen_wait", 32'(shiftreg_loadn), 32'd1);
        edges(1);
        chk("reen_load", 32'(shiftreg_loadn), 32'd0);
        wait_valid(1'b0, at);
        chk("reen_at", 32'(at - last), 32'd166);
        check_scan("reen_scan", 16'h3C3C);

        // Reset in the middle of bit 7
        edges(35);
        chk("pre_rst_buttons", 32'(buttons != 16'h0), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_pins", 32'({shiftreg_clk, shiftreg_loadn}), 32'b01);
        chk("mid_rst_buttons", 32'(buttons), 32'h0);
        chk("mid_rst_valid", 32'(buttons_valid), 32'd0);
        do_reset(16'h1234);
        wait_valid(1'b0, at);
        chk("fresh_at", 32'(at), 32'd64);
        check_scan("fresh", 16'h1234);

        // Zero-gap instance: back-to-back scans
        chk("g0_valid", 32'(g_valid), 32'd1);
        chk("g0_load", 32'(g_loadn), 32'd0);
`ifdef BUTTON_DEBOUNCE_EN
        chk("g0_btn1", 32'({g_buttons, g_changed}), 32'h0_0000);
`else
        chk("g0_btn1", 32'({g_buttons, g_changed}), 32'h1_E1E1);
`endif
        wait_valid(1'b1, at);
        chk("g0_period", 32'(at), 32'd128);
`ifdef BUTTON_DEBOUNCE_EN
        chk("g0_btn2", 32'({g_buttons, g_changed}), 32'h1_E1E1);
`else
        chk("g0_btn2", 32'({g_buttons, g_changed}), 32'h1_E1E0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
